// File: rtl/sp_ram_req_arbiter.sv
// Round-robin front end sharing one single-port RAM among NUM_REQS requesters:
// posted writes, backpressured read responses and a hardware clear sequencer.
module sp_ram_req_arbiter #(
    parameter int               NUM_REQS       = 4,
    parameter int               DATAW          = 32,
    parameter int               SIZE           = 256,
    parameter int               BYTEENW        = 1,
    parameter int               ADDRW          = $clog2(SIZE),
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [DATAW-1:0] INIT_VALUE     = '0,
    parameter int               IDXW           = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    output logic                          busy,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS-1:0]           req_rw,
    input  logic [NUM_REQS*BYTEENW-1:0]   req_byteen,
    input  logic [NUM_REQS*ADDRW-1:0]     req_addr,
    input  logic [NUM_REQS*DATAW-1:0]     req_data,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic                          rsp_valid,
    output logic [IDXW-1:0]               rsp_idx,
    output logic [DATAW-1:0]              rsp_data,
    input  logic                          rsp_ready,
    output logic                          ram_en,
    output logic [ADDRW-1:0]              ram_addr,
    output logic [BYTEENW-1:0]            ram_wren,
    output logic [DATAW-1:0]              ram_wdata,
    input  logic [DATAW-1:0]              ram_rdata
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state, state_next;
    logic [ADDRW-1:0]  clr_cnt, clr_cnt_next;
    logic [IDXW-1:0]   rr_ptr;
    logic [IDXW-1:0]   cand;
    logic              can_issue;
    logic              grant_valid;
    logic [IDXW-1:0]   grant_idx;
    logic              grant_rw;
    logic [BYTEENW-1:0] grant_byteen;
    logic [ADDRW-1:0]  grant_addr;
    logic [DATAW-1:0]  grant_data;

    // The RAM holds rdata while ram_en=0, so a stalled response needs no local copy.
    assign rsp_data  = ram_rdata;
    assign busy      = (state == ST_CLEAR);
    assign can_issue = !rsp_valid || rsp_ready;

    // Search starts one past the last winner, wrapping modulo NUM_REQS.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (!reset && !flush && state == ST_RUN && can_issue) begin
            for (int k = 1; k <= NUM_REQS; k++) begin
                cand = IDXW'((int'(rr_ptr) + k) % NUM_REQS);
                if (!grant_valid && req_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    assign grant_rw     = req_rw[grant_idx];
    assign grant_byteen = req_byteen[grant_idx*BYTEENW +: BYTEENW];
    assign grant_addr   = req_addr[grant_idx*ADDRW +: ADDRW];
    assign grant_data   = req_data[grant_idx*DATAW +: DATAW];

    always_comb begin
        ram_en    = 1'b0;
        ram_addr  = '0;
        ram_wren  = '0;
        ram_wdata = '0;
        req_ready = '0;
        if (!reset) begin
            if (state == ST_CLEAR) begin
                ram_en    = 1'b1;
                ram_addr  = clr_cnt;
                ram_wren  = '1;
                ram_wdata = INIT_VALUE;
            end else if (grant_valid) begin
                ram_en    = 1'b1;
                ram_addr  = grant_addr;
                ram_wdata = grant_data;
                ram_wren  = grant_rw ? grant_byteen : '0;
                req_ready[grant_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        if (state == ST_CLEAR) begin
            if (clr_cnt == ADDRW'(SIZE - 1)) begin
                state_next   = ST_RUN;
                clr_cnt_next = '0;
            end else begin
                clr_cnt_next = clr_cnt + ADDRW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt   <= '0;
            rr_ptr    <= IDXW'(NUM_REQS - 1);
            rsp_valid <= 1'b0;
            rsp_idx   <= '0;
        end else if (flush) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
            if (grant_valid) begin
                rr_ptr <= grant_idx;
            end
            if (grant_valid && !grant_rw) begin
                rsp_valid <= 1'b1;
                rsp_idx   <= grant_idx;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_req_arbiter.sv
// Bench for sp_ram_req_arbiter: RAM model, directed vector table, hand-written
// stall/flush sequences and randomized traffic against a behavioural model.
module tb_sp_ram_req_arbiter;

    localparam int               N     = 4;
    localparam int               DW    = 32;
    localparam int               SZ    = 16;
    localparam int               BW    = 4;
    localparam int               AW    = 4;
    localparam bit               COR   = 1'b1;
    localparam logic [DW-1:0]    INITV = 32'hA5A5A5A5;

    logic              clk;
    logic              reset, flush, busy;
    logic [N-1:0]      req_valid, req_rw, req_ready;
    logic [N*BW-1:0]   req_byteen;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_idx;
    logic [DW-1:0]     rsp_data;
    logic              ram_en;
    logic [AW-1:0]     ram_addr;
    logic [BW-1:0]     ram_wren;
    logic [DW-1:0]     ram_wdata, ram_rdata;

    sp_ram_req_arbiter #(
        .NUM_REQS(N), .DATAW(DW), .SIZE(SZ), .BYTEENW(BW), .ADDRW(AW),
        .CLEAR_ON_RESET(COR), .INIT_VALUE(INITV), .IDXW(2)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .busy(busy),
        .req_valid(req_valid), .req_rw(req_rw), .req_byteen(req_byteen),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .ram_en(ram_en), .ram_addr(ram_addr),
        .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Physical single-port RAM: registered read-first, byte writes, rdata holds when idle.
    logic [DW-1:0] mem [SZ];
    initial begin
        for (int i = 0; i < SZ; i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            for (int b = 0; b < BW; b++)
                if (ram_wren[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clear position (-1 = running), pointer, pending response, shadow memory.
    int            m_clr = 0;
    int            m_rr = N - 1;
    bit            m_rv = 0;
    int            m_ri = 0;
    logic [DW-1:0] m_rd = '0;
    logic [DW-1:0] m_mem [SZ];
    int            m_w = -1;

    task automatic sample();
        logic [N-1:0] e_ready;
        @(negedge clk);
        m_w = -1;
        if (reset) begin
            check("rst_ready", req_ready, 0);
            check("rst_ram_en", ram_en, 0);
        end else if (m_clr >= 0) begin
            check("clr_busy", busy, 1);
            check("clr_ready", req_ready, 0);
            check("clr_rsp_valid", rsp_valid, 0);
            if (!flush) begin
                check("clr_ram_en", ram_en, 1);
                check("clr_ram_addr", ram_addr, m_clr);
                check("clr_ram_wren", ram_wren, 4'hF);
                check("clr_ram_wdata", ram_wdata, INITV);
            end
        end else begin
            check("run_busy", busy, 0);
            if (!flush && (!m_rv || rsp_ready)) begin
                for (int k = 1; k <= N; k++)
                    if (m_w < 0 && req_valid[(m_rr + k) % N]) m_w = (m_rr + k) % N;
            end
            e_ready = (m_w >= 0) ? N'(1 << m_w) : '0;
            check("model_ready", req_ready, e_ready);
            check("model_ram_en", ram_en, (m_w >= 0) ? 1 : 0);
            if (m_w >= 0) begin
                check("model_ram_addr", ram_addr, req_addr[m_w*AW +: AW]);
                check("model_ram_wdata", ram_wdata, req_data[m_w*DW +: DW]);
                check("model_ram_wren", ram_wren, req_rw[m_w] ? req_byteen[m_w*BW +: BW] : 4'h0);
            end
            check("model_rsp_valid", rsp_valid, m_rv);
            if (m_rv) begin
                check("model_rsp_idx", rsp_idx, m_ri);
                check("model_rsp_data", rsp_data, m_rd);
            end
        end
    endtask

    task automatic advance();
        int a;
        if (reset) begin
            m_clr = COR ? 0 : -1;
            m_rr  = N - 1;
            m_rv  = 0;
        end else if (flush) begin
            m_clr = 0;
            m_rv  = 0;
        end else if (m_clr >= 0) begin
            m_mem[m_clr] = INITV;
            m_clr = (m_clr == SZ - 1) ? -1 : m_clr + 1;
        end else begin
            if (m_rv && rsp_ready) m_rv = 0;
            if (m_w >= 0) begin
                m_rr = m_w;
                a = int'(req_addr[m_w*AW +: AW]);
                if (req_rw[m_w]) begin
                    for (int b = 0; b < BW; b++)
                        if (req_byteen[m_w*BW + b]) m_mem[a][8*b +: 8] = req_data[m_w*DW + 8*b +: 8];
                end else begin
                    m_rv = 1;
                    m_ri = m_w;
                    m_rd = m_mem[a];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic set_req(input logic [3:0] v, input logic [3:0] rw, input logic [3:0] be,
                           input logic [15:0] addr, input logic [31:0] data, input logic rr);
        req_valid  = v;
        req_rw     = rw;
        req_byteen = {N{be}};
        req_addr   = addr;
        req_data   = {N{data}};
        rsp_ready  = rr;
    endtask

    // Counts busy cycles until the DUT leaves CLEAR, giving up after 40 cycles.
    task automatic count_clear(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (!busy) begin
                advance();
                break;
            end
            n++;
            advance();
        end
    endtask

    typedef struct {
        logic [3:0]  valid, rw, byteen;
        logic [15:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  e_ready;
        logic        e_rv;
        logic [1:0]  e_ri;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(logic [3:0] v, logic [3:0] rw, logic [3:0] be, logic [15:0] a,
                                logic [31:0] d, logic rr, logic [3:0] er, logic erv,
                                logic [1:0] eri, logic [31:0] erd);
        vec_t t;
        t.valid = v; t.rw = rw; t.byteen = be; t.addr = a; t.data = d; t.rdy = rr;
        t.e_ready = er; t.e_rv = erv; t.e_ri = eri; t.e_rd = erd;
        return t;
    endfunction

    vec_t vt [13];

    initial begin
        int n;
        vt[0]  = mk(4'b0001, 4'b0000, 4'hF, 16'h0000, 32'h0,        1, 4'b0001, 0, 0, 32'h0);
        vt[1]  = mk(4'b0001, 4'b0000, 4'hF, 16'h000F, 32'h0,        1, 4'b0001, 1, 0, INITV);
        vt[2]  = mk(4'b1111, 4'b0000, 4'hF, 16'h4321, 32'h0,        1, 4'b0010, 1, 0, INITV);
        vt[3]  = mk(4'b1111, 4'b0000, 4'hF, 16'h4321, 32'h0,        1, 4'b0100, 1, 1, INITV);
        vt[4]  = mk(4'b1111, 4'b0000, 4'hF, 16'h4321, 32'h0,        1, 4'b1000, 1, 2, INITV);
        vt[5]  = mk(4'b1111, 4'b0000, 4'hF, 16'h4321, 32'h0,        1, 4'b0001, 1, 3, INITV);
        vt[6]  = mk(4'b1111, 4'b0000, 4'hF, 16'h4321, 32'h0,        1, 4'b0010, 1, 0, INITV);
        vt[7]  = mk(4'b0100, 4'b0100, 4'hF, 16'h0500, 32'hDEADBEEF, 1, 4'b0100, 1, 1, INITV);
        vt[8]  = mk(4'b0001, 4'b0000, 4'hF, 16'h0005, 32'h0,        1, 4'b0001, 0, 0, 32'h0);
        vt[9]  = mk(4'b0010, 4'b0010, 4'h5, 16'h0060, 32'h11223344, 1, 4'b0010, 1, 0, 32'hDEADBEEF);
        vt[10] = mk(4'b0010, 4'b0000, 4'hF, 16'h0060, 32'h0,        1, 4'b0010, 0, 0, 32'h0);
        vt[11] = mk(4'b0000, 4'b0000, 4'hF, 16'h0000, 32'h0,        1, 4'b0000, 1, 1, 32'hA522A544);
        vt[12] = mk(4'b0000, 4'b0000, 4'hF, 16'h0000, 32'h0,        1, 4'b0000, 0, 0, 32'h0);

        reset = 1'b1;
        flush = 1'b0;
        set_req(4'b0, 4'b0, 4'h0, 16'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) tick();

        // Clear after reset: exactly SIZE busy cycles walking addresses 0..SIZE-1.
        reset = 1'b0;
        count_clear(n);
        check("reset_clear_cycles", n, SZ);

        for (int i = 0; i < 13; i++) begin
            set_req(vt[i].valid, vt[i].rw, vt[i].byteen, vt[i].addr, vt[i].data, vt[i].rdy);
            sample();
            check($sformatf("vec%0d_ready", i), req_ready, vt[i].e_ready);
            check($sformatf("vec%0d_rsp_valid", i), rsp_valid, vt[i].e_rv);
            if (vt[i].e_rv) begin
                check($sformatf("vec%0d_rsp_idx", i), rsp_idx, vt[i].e_ri);
                check($sformatf("vec%0d_rsp_data", i), rsp_data, vt[i].e_rd);
            end
            advance();
        end

        // Backpressure: requester 3 reads addr 6, consumer stalls for three cycles.
        set_req(4'b1000, 4'b0000, 4'hF, 16'h6000, 32'h0, 1'b0);
        sample();
        check("stall_grant", req_ready, 4'b1000);
        advance();
        set_req(4'b1111, 4'b0000, 4'hF, 16'h4321, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sample();
            check("stall_ready", req_ready, 4'b0000);
            check("stall_ram_en", ram_en, 0);
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_idx", rsp_idx, 3);
            check("stall_rsp_data", rsp_data, 32'hA522A544);
            advance();
        end
        rsp_ready = 1'b1;
        sample();
        check("drain_grant", req_ready, 4'b0001);
        check("drain_rsp_valid", rsp_valid, 1);
        advance();
        set_req(4'b0000, 4'b0000, 4'hF, 16'h0000, 32'h0, 1'b1);
        sample();
        check("drain_next_idx", rsp_idx, 0);
        check("drain_next_data", rsp_data, INITV);
        advance();

        // Flush with a pending response, then again part-way through the clear.
        set_req(4'b0001, 4'b0000, 4'hF, 16'h0000, 32'h0, 1'b0);
        tick();
        set_req(4'b0001, 4'b0000, 4'hF, 16'h0000, 32'h0, 1'b0);
        flush = 1'b1;
        sample();
        check("flush_cycle_ready", req_ready, 4'b0000);
        check("flush_cycle_rsp_valid", rsp_valid, 1);
        advance();
        flush = 1'b0;
        sample();
        check("post_flush_rsp_valid", rsp_valid, 0);
        check("post_flush_busy", busy, 1);
        check("post_flush_addr", ram_addr, 0);
        advance();
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sample();
        check("reflush_addr", ram_addr, 0);
        advance();
        count_clear(n);
        check("reflush_clear_cycles", n + 1, SZ);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            req_valid  = N'($urandom);
            req_rw     = N'($urandom);
            req_byteen = (N*BW)'($urandom);
            req_addr   = (N*AW)'($urandom);
            req_data   = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 79) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;
        set_req(4'b0, 4'b0, 4'h0, 16'h0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
